memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM pipeline buffer plus the data memory.
// Inputs are captured every rising edge. The memory is read asynchronously
// and written at the end of the cycle that holds the store. Branch select is
// decoded from the buffer.
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag and suppress accesses
// whose byte address is not doubleword aligned.
`ifndef WORD
`define WORD 64
`endif

module memory_stage #(
  parameter int DEPTH = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [`WORD-1:0]   alu_result_in,
  input  logic [`WORD-1:0]   branch_target_in,
  input  logic [`WORD-1:0]   read_data2_in,
  input  logic               zero_in,
  input  logic [4:0]         write_register_in,
  input  logic               reg_write_in,
  input  logic               uncond_branch_in,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_to_reg_in,
  input  logic               mem_write_in,
  output logic               pc_src,
  output logic [`WORD-1:0]   branch_target_out,
  output logic [`WORD-1:0]   read_data_out,
  output logic [`WORD-1:0]   alu_result_out,
  output logic [4:0]         write_register_out,
  output logic               reg_write_out,
  output logic               mem_to_reg_out,
  output logic               misaligned
);

  localparam int ADDR_W = $clog2(DEPTH);

  // EX/MEM buffer fields
  logic [`WORD-1:0] alu_result_reg;
  logic [`WORD-1:0] branch_target_reg;
  logic [`WORD-1:0] read_data2_reg;
  logic             zero_reg;
  logic [4:0]       write_register_reg;
  logic             reg_write_reg;
  logic             uncond_branch_reg;
  logic             branch_reg;
  logic             mem_read_reg;
  logic             mem_to_reg_reg;
  logic             mem_write_reg;

  // Data memory: contents survive reset on purpose
  logic [`WORD-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] mem_index;
  logic              misaligned_int;
  logic              mem_we;

  // Capture every execute-stage field on each edge; reset clears them at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_reg     <= '0;
      branch_target_reg  <= '0;
      read_data2_reg     <= '0;
      zero_reg           <= 1'b0;
      write_register_reg <= '0;
      reg_write_reg      <= 1'b0;
      uncond_branch_reg  <= 1'b0;
      branch_reg         <= 1'b0;
      mem_read_reg       <= 1'b0;
      mem_to_reg_reg     <= 1'b0;
      mem_write_reg      <= 1'b0;
    end else begin
      alu_result_reg     <= alu_result_in;
      branch_target_reg  <= branch_target_in;
      read_data2_reg     <= read_data2_in;
      zero_reg           <= zero_in;
      write_register_reg <= write_register_in;
      reg_write_reg      <= reg_write_in;
      uncond_branch_reg  <= uncond_branch_in;
      branch_reg         <= branch_in;
      mem_read_reg       <= mem_read_in;
      mem_to_reg_reg     <= mem_to_reg_in;
      mem_write_reg      <= mem_write_in;
    end
  end

  // Doubleword index; upper address bits are dropped so accesses wrap
  assign mem_index = alu_result_reg[ADDR_W+2:3];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned_int = (mem_read_reg | mem_write_reg) & (|alu_result_reg[2:0]);
`else
  assign misaligned_int = 1'b0;
`endif

  // A cleared buffer (reset asserted) never requests a write
  assign mem_we = mem_write_reg & ~misaligned_int;

  // Commit the buffered store at the edge that ends its cycle
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_index] <= read_data2_reg;
    end
  end

  // Asynchronous read sees pre-write contents during a read+write cycle
  always_comb begin
    read_data_out = '0;
    if (mem_read_reg && !misaligned_int) begin
      read_data_out = mem[mem_index];
    end
  end

  assign pc_src             = uncond_branch_reg | (branch_reg & zero_reg);
  assign branch_target_out  = branch_target_reg;
  assign alu_result_out     = alu_result_reg;
  assign write_register_out = write_register_reg;
  assign reg_write_out      = reg_write_reg;
  assign mem_to_reg_out     = mem_to_reg_reg;
  assign misaligned         = misaligned_int;

endmodule
